// File: rtl/ahb_xfer_sched_if.sv
// Bundle between the AXI-to-AHB transfer scheduler and the per-path request logic / AHB port.
// master: scheduler side; slave: request logic and AHB bus side.
interface ahb_xfer_sched_if #(
  parameter int unsigned LEN_W = 8
);
  logic             rd_req;
  logic [LEN_W-1:0] rd_len;
  logic             rd_done;
  logic             wr_req;
  logic [LEN_W-1:0] wr_len;
  logic             wr_done;
  logic             hready;
  logic [1:0]       htrans;
  logic             hwrite;
  logic             addr_inc;
  logic             ph1_valid;
  logic             ph1_rd;
  logic             ph2_valid;
  logic             ph2_rd;

  modport master (
    input  rd_req, rd_len, wr_req, wr_len, hready,
    output rd_done, wr_done, htrans, hwrite, addr_inc,
    output ph1_valid, ph1_rd, ph2_valid, ph2_rd
  );

  modport slave (
    output rd_req, rd_len, wr_req, wr_len, hready,
    input  rd_done, wr_done, htrans, hwrite, addr_inc,
    input  ph1_valid, ph1_rd, ph2_valid, ph2_rd
  );
endinterface

// File: rtl/ahb_xfer_sched.sv
// AHB transfer scheduler: arbitrates read/write paths and sequences each AXI burst as AHB INCR.
// Define SCHED_WR_PRIO_EN for fixed write-over-read priority instead of round-robin.
module ahb_xfer_sched #(
  parameter int unsigned LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  ahb_xfer_sched_if.master  bus
);

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic             grant_rd_q, grant_rd_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;   // NONSEQ issued but not yet accepted
  logic             pend_q, pend_d;     // SEQ issued but stalled by hready
  logic             ph1_valid_q, ph1_valid_d;
  logic             ph1_rd_q, ph1_rd_d;
`ifndef SCHED_WR_PRIO_EN
  logic             rr_q, rr_d;         // 1: write preferred on the next contended grant
`endif

  logic             req_any, pick_rd, cur_rd, path_req, accept, last;
  logic [LEN_W-1:0] cur_cnt;
  logic [1:0]       htrans_c;
  logic             hwrite_c;

  // Gated by rst so every output reads 0 while reset is held.
  assign req_any = ~rst & (bus.rd_req | bus.wr_req);
`ifdef SCHED_WR_PRIO_EN
  assign pick_rd = ~bus.wr_req;
`else
  assign pick_rd = bus.rd_req & (~bus.wr_req | ~rr_q);
`endif
  assign path_req = grant_rd_q ? bus.rd_req : bus.wr_req;

  always_comb begin
    state_d    = state_q;
    grant_rd_d = grant_rd_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    pend_d     = pend_q;
`ifndef SCHED_WR_PRIO_EN
    rr_d       = rr_q;
`endif
    cur_rd     = grant_rd_q;
    cur_cnt    = cnt_q;
    htrans_c   = TrIdle;
    hwrite_c   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          cur_rd     = pick_rd;
          cur_cnt    = pick_rd ? bus.rd_len : bus.wr_len;
          htrans_c   = TrNonseq;
          hwrite_c   = ~pick_rd;
          state_d    = StBurst;
          grant_rd_d = pick_rd;
          cnt_d      = cur_cnt;
          first_d    = 1'b1;
          pend_d     = 1'b0;
`ifndef SCHED_WR_PRIO_EN
          rr_d       = pick_rd;
`endif
        end
      end
      StBurst: begin
        hwrite_c = ~grant_rd_q;
        if (first_q)                 htrans_c = TrNonseq;
        else if (pend_q || path_req) htrans_c = TrSeq;
        else                         htrans_c = TrBusy;
      end
      default: ;
    endcase

    accept = htrans_c[1] & bus.hready;
    last   = accept & (cur_cnt == '0);
    if (accept) begin
      first_d = 1'b0;
      if (cur_cnt == '0) state_d = StIdle;
      else               cnt_d   = cur_cnt - LEN_W'(1);
    end
    pend_d = (htrans_c == TrSeq) & ~bus.hready;

    ph1_valid_d = bus.hready ? htrans_c[1] : ph1_valid_q;
    ph1_rd_d    = bus.hready ? ~hwrite_c   : ph1_rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_rd_q  <= 1'b0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      pend_q      <= 1'b0;
      ph1_valid_q <= 1'b0;
      ph1_rd_q    <= 1'b0;
`ifndef SCHED_WR_PRIO_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_rd_q  <= grant_rd_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      pend_q      <= pend_d;
      ph1_valid_q <= ph1_valid_d;
      ph1_rd_q    <= ph1_rd_d;
`ifndef SCHED_WR_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign bus.htrans    = htrans_c;
  assign bus.hwrite    = hwrite_c;
  assign bus.addr_inc  = accept;
  assign bus.rd_done   = last & cur_rd;
  assign bus.wr_done   = last & ~cur_rd;
  assign bus.ph1_valid = ph1_valid_q;
  assign bus.ph1_rd    = ph1_rd_q;
  assign bus.ph2_valid = ph1_valid_q & bus.hready;
  assign bus.ph2_rd    = ph1_rd_q;

endmodule

// File: tb/tb_ahb_xfer_sched.sv
// Bench for ahb_xfer_sched: burst-level reference model checked every cycle, plus directed
// scenarios with literal expectations. Honours SCHED_WR_PRIO_EN like the design.
module tb_ahb_xfer_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  ahb_xfer_sched_if #(.LEN_W(8)) bus ();

  ahb_xfer_sched #(.LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks a burst as "beats still to be accepted" for the granted path.
  bit m_busy = 0, m_rd = 0, m_started = 0, m_hold = 0, m_pref_wr = 0;
  bit m_ph1v = 0, m_ph1r = 0;
  int m_left = 0;

  always @(negedge clk) begin
    logic [1:0]  t;
    logic        w, acc, dn, prd;
    int          left;
    logic [10:0] exp_v, act_v;
    if (rst) begin
      exp_v = '0;
      m_busy = 0; m_pref_wr = 0; m_ph1v = 0; m_ph1r = 0; m_hold = 0; m_started = 0;
    end else begin
      t = 2'd0; w = 1'b0; left = 0; prd = 1'b0;
      if (!m_busy) begin
        if (bus.rd_req || bus.wr_req) begin
`ifdef SCHED_WR_PRIO_EN
          prd = !bus.wr_req;
`else
          prd = (bus.rd_req && bus.wr_req) ? !m_pref_wr : bus.rd_req;
`endif
          t = 2'd2; w = !prd;
          left = (prd ? int'(bus.rd_len) : int'(bus.wr_len)) + 1;
          m_busy = 1; m_rd = prd; m_left = left; m_started = 0; m_hold = 0; m_pref_wr = prd;
        end
      end else begin
        prd = m_rd; w = !m_rd; left = m_left;
        if (!m_started)                               t = 2'd2;
        else if (m_hold || (m_rd ? bus.rd_req : bus.wr_req)) t = 2'd3;
        else                                          t = 2'd1;
      end
      acc = t[1] && bus.hready;
      dn  = acc && (left == 1);
      exp_v = {t, w, acc, dn && prd, dn && !prd, m_ph1v, m_ph1r, m_ph1v && bus.hready, m_ph1r};
      if (acc) begin
        m_left--; m_started = 1;
        if (m_left == 0) m_busy = 0;
      end
      m_hold = (t == 2'd3) && !bus.hready;
      if (bus.hready) begin m_ph1v = t[1]; m_ph1r = !w; end
    end
    act_v = {bus.htrans, bus.hwrite, bus.addr_inc, bus.rd_done, bus.wr_done,
             bus.ph1_valid, bus.ph1_rd, bus.ph2_valid, bus.ph2_rd};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model_cycle: got %b expected %b {htrans,hwrite,inc,rdd,wrd,p1v,p1r,p2v,p2r} t=%0t",
               act_v, exp_v, $time);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ninc;
    logic [1:0] exp_t1 [5];
    logic [1:0] exp_t3 [5];
    exp_t1 = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    exp_t3 = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd3};
    bus.rd_req = 0; bus.wr_req = 0; bus.rd_len = 0; bus.wr_len = 0; bus.hready = 1;

    @(negedge clk);
    chk("rst_htrans", bus.htrans, 0);
    chk("rst_hwrite", bus.hwrite, 0);
    chk("rst_ph1_valid", bus.ph1_valid, 0);
    nxt();
    rst = 1'b0;

    // 1: read burst of 4 beats
    bus.rd_len = 3; bus.rd_req = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 5) chk("t1_htrans", bus.htrans, exp_t1[i]);
      chk("t1_rd_done", bus.rd_done, (i == 3) ? 1 : 0);
      if (i == 0) chk("t1_ph1_valid0", bus.ph1_valid, 0);
      if (i >= 1 && i <= 4) begin
        chk("t1_ph1_valid", bus.ph1_valid, 1);
        chk("t1_ph1_rd", bus.ph1_rd, 1);
      end
      if (i == 5) chk("t1_ph1_valid_end", bus.ph1_valid, 0);
      nxt();
      if (i == 3) bus.rd_req = 0;
    end

    do_reset();
`ifndef SCHED_WR_PRIO_EN
    // 2: contended single-beat bursts alternate with no gap
    bus.rd_len = 0; bus.wr_len = 0; bus.rd_req = 1; bus.wr_req = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_htrans", bus.htrans, 2);
      chk("t2_hwrite", bus.hwrite, i % 2);
      chk("t2_rd_done", bus.rd_done, (i % 2 == 0) ? 1 : 0);
      chk("t2_wr_done", bus.wr_done, i % 2);
      nxt();
    end
    bus.rd_req = 0; bus.wr_req = 0;
    nxt();
`endif

    // 3: write burst with BUSY stalls
    bus.wr_len = 2; bus.wr_req = 1; ninc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_htrans", bus.htrans, exp_t3[i]);
      chk("t3_wr_done", bus.wr_done, (i == 4) ? 1 : 0);
      if (bus.addr_inc) ninc++;
      nxt();
      if (i == 0) bus.wr_req = 0;
      if (i == 2) bus.wr_req = 1;
      if (i == 4) bus.wr_req = 0;
    end
    chk("t3_addr_inc_count", ninc, 3);

    // 4: hready stall on second read beat
    bus.rd_len = 1; bus.rd_req = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("t4_htrans0", bus.htrans, 2);
      else        chk("t4_htrans", bus.htrans, 3);
      if (i >= 1) chk("t4_ph1_valid", bus.ph1_valid, 1);
      chk("t4_rd_done", bus.rd_done, (i == 4) ? 1 : 0);
      nxt();
      if (i == 0) bus.hready = 0;
      if (i == 3) bus.hready = 1;
      if (i == 4) bus.rd_req = 0;
    end

    // 5: reset mid-burst with cnt at 5
    bus.rd_len = 7; bus.rd_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_rd_done", bus.rd_done, 0);
      nxt();
    end
    rst = 1'b1;
    #1;
    chk("t5_async_htrans", bus.htrans, 0);
    chk("t5_async_inc", bus.addr_inc, 0);
    chk("t5_async_rd_done", bus.rd_done, 0);
    chk("t5_async_ph1_valid", bus.ph1_valid, 0);
    chk("t5_async_ph2_valid", bus.ph2_valid, 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_restart_htrans", bus.htrans, 2);
    chk("t5_restart_rd_done", bus.rd_done, 0);
    nxt();
    bus.rd_req = 0;
    do_reset();

`ifdef SCHED_WR_PRIO_EN
    // 6: writes win every contended grant
    bus.rd_len = 0; bus.wr_len = 0; bus.rd_req = 1; bus.wr_req = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_hwrite", bus.hwrite, (i < 3) ? 1 : 0);
      chk("t6_wr_done", bus.wr_done, (i < 3) ? 1 : 0);
      chk("t6_rd_done", bus.rd_done, (i >= 3) ? 1 : 0);
      nxt();
      if (i == 2) bus.wr_req = 0;
    end
    bus.rd_req = 0;
    nxt();
`endif

    // 7: maximum length gives 2^LEN_W beats
    bus.rd_len = 8'hff; bus.rd_req = 1; ninc = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk);
        if (bus.addr_inc) ninc++;
        if (bus.rd_done) seen = 1;
        nxt();
      end
      bus.rd_req = 0;
      chk("t7_done_seen", seen, 1);
      chk("t7_beats", ninc, 256);
    end
    nxt();
    nxt();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
